// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings and counter sizing.
// Imported by the SPI slave top and its interface users.
package spi_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int cnt_w(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/spi_slave_gen_if.sv
// Bundle of SPI pins and the tx/rx word handshake of the slave.
// slave = the spi_slave_gen side, master = pin driver / word user.
interface spi_slave_gen_if #(
  parameter int DATA_W = 8
);

  logic              sck;
  logic              mosi;
  logic              ssel;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_underrun;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              frame_active;
  logic              frame_abort;

  modport slave (
    input  sck, mosi, ssel, tx_data, tx_valid,
    output miso, miso_oe, tx_ready, tx_underrun,
    output rx_data, rx_valid, frame_active, frame_abort
  );

  modport master (
    output sck, mosi, ssel, tx_data, tx_valid,
    input  miso, miso_oe, tx_ready, tx_underrun,
    input  rx_data, rx_valid, frame_active, frame_abort
  );

endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser with a history flop for edge pulses.
// Flops reset to IDLE so reset never creates a false edge.
module spi_edge_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // shift the async input through the chain, keep last level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE}};
      hist_q <= IDLE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign lvl_o  = sync_q[SYNC_STAGES-1];
  assign rise_o = lvl_o & ~hist_q;
  assign fall_o = ~lvl_o & hist_q;

endmodule

// File: rtl/spi_slave_gen.sv
// Oversampled SPI slave: any width, any CPOL/CPHA, MSB/LSB first.
// One-deep tx holding register, single-cycle rx word strobes.
module spi_slave_gen
  import spi_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] TX_DEFAULT = '0
) (
  input logic            clk,
  input logic            rst_n,
  spi_slave_gen_if.slave bus
);

  localparam int CW = cnt_w(DATA_W);
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic ssel_lvl, ssel_rise, ssel_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic unused_sync;

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .IDLE       (1'(CPOL))
  ) u_sck (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.sck),
    .lvl_o (sck_lvl),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .IDLE       (1'b1)
  ) u_ssel (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.ssel),
    .lvl_o (ssel_lvl),
    .rise_o(ssel_rise),
    .fall_o(ssel_fall)
  );

  spi_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .IDLE       (1'b0)
  ) u_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.mosi),
    .lvl_o (mosi_lvl),
    .rise_o(mosi_rise),
    .fall_o(mosi_fall)
  );

  assign unused_sync = ^{sck_lvl, mosi_rise, mosi_fall};

  logic frame_act;
  logic edge_ok;
  logic lead, trail;
  logic sample_e, shift_e;
  logic load, capture;

  assign frame_act = ~ssel_lvl;
  // a frame start swallows any sck edge seen in the same cycle
  assign edge_ok   = frame_act & ~ssel_fall;
  assign lead      = (CPOL != 0) ? sck_fall : sck_rise;
  assign trail     = (CPOL != 0) ? sck_rise : sck_fall;
  assign sample_e  = edge_ok & ((CPHA != 0) ? trail : lead);
  assign shift_e   = edge_ok & ((CPHA != 0) ? lead : trail);

  logic [CW-1:0]     bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              abort_q, abort_d;

  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              full_q, full_d;
  logic              unr_q, unr_d;

  // CPHA=0 loads at frame start and on the shift edge after a wrap;
  // CPHA=1 loads on the leading edge that opens each word
  assign load = ((CPHA == 0) && ssel_fall)
              | (shift_e && (bitcnt_q == '0));
  assign capture = bus.tx_valid & ~full_q;

  // receive shifter, bit counter and frame-abort detection
  always_comb begin
    bitcnt_d   = bitcnt_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    abort_d    = 1'b0;
    if (!frame_act) begin
      bitcnt_d = '0;
      abort_d  = ssel_rise && (bitcnt_q != '0);
    end else if (sample_e) begin
      if (MSB_FIRST != 0) begin
        rx_sh_d = {rx_sh_q[DATA_W-2:0], mosi_lvl};
      end else begin
        rx_sh_d = {mosi_lvl, rx_sh_q[DATA_W-1:1]};
      end
      if (bitcnt_q == LAST) begin
        bitcnt_d   = '0;
        rx_data_d  = rx_sh_d;
        rx_valid_d = 1'b1;
      end else begin
        bitcnt_d = bitcnt_q + 1'b1;
      end
    end
  end

  // transmit shifter and one-deep holding register
  always_comb begin
    tx_sh_d = tx_sh_q;
    hold_d  = hold_q;
    full_d  = full_q;
    unr_d   = 1'b0;
    if (load) begin
      if (full_q) begin
        tx_sh_d = hold_q;
        full_d  = 1'b0;
      end else if (capture) begin
        tx_sh_d = bus.tx_data;
      end else begin
        tx_sh_d = TX_DEFAULT;
        unr_d   = 1'b1;
      end
    end else begin
      if (shift_e) begin
        if (MSB_FIRST != 0) begin
          tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
        end else begin
          tx_sh_d = {1'b0, tx_sh_q[DATA_W-1:1]};
        end
      end
      if (capture) begin
        hold_d = bus.tx_data;
        full_d = 1'b1;
      end
    end
  end

  // state registers for both paths
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      abort_q    <= 1'b0;
      tx_sh_q    <= '0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      unr_q      <= 1'b0;
    end else begin
      bitcnt_q   <= bitcnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      abort_q    <= abort_d;
      tx_sh_q    <= tx_sh_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      unr_q      <= unr_d;
    end
  end

  assign bus.miso         = (MSB_FIRST != 0) ? tx_sh_q[DATA_W-1]
                                             : tx_sh_q[0];
  assign bus.miso_oe      = frame_act;
  assign bus.frame_active = frame_act;
  assign bus.tx_ready     = ~full_q;
  assign bus.tx_underrun  = unr_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.frame_abort  = abort_q;

endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench: one 8-bit mode-0 slave, three 16-bit LSB-first
// slaves in modes 1..3, driven by a bit-banged SPI master task.
module tb_spi_slave_gen;

  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        sck_t  [4];
  logic        ssel_t [4];
  logic        mosi_t [4];
  logic [15:0] txd_t  [4];
  logic        txv_t  [4];

  logic        miso_w [4];
  logic        rdy_w  [4];
  logic        rxv_w  [4];
  logic        unr_w  [4];
  logic        abt_w  [4];
  logic [15:0] rxd_w  [4];

  int          rxv_cnt [4] = '{default: 0};
  int          unr_cnt [4] = '{default: 0};
  int          abt_cnt [4] = '{default: 0};
  logic [15:0] rx_last [4] = '{default: '0};

  int ncmp = 0;
  int nfail = 0;

  spi_slave_gen_if #(.DATA_W(8)) if0 ();

  spi_slave_gen #(
    .DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(1),
    .SYNC_STAGES(2), .TX_DEFAULT(8'h00)
  ) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (if0.slave)
  );

  assign if0.sck      = sck_t[0];
  assign if0.ssel     = ssel_t[0];
  assign if0.mosi     = mosi_t[0];
  assign if0.tx_data  = txd_t[0][7:0];
  assign if0.tx_valid = txv_t[0];
  assign miso_w[0]    = if0.miso;
  assign rdy_w[0]     = if0.tx_ready;
  assign rxv_w[0]     = if0.rx_valid;
  assign unr_w[0]     = if0.tx_underrun;
  assign abt_w[0]     = if0.frame_abort;
  assign rxd_w[0]     = {8'h00, if0.rx_data};

  for (genvar g = 1; g < 4; g++) begin : g16
    spi_slave_gen_if #(.DATA_W(16)) bus16 ();
    spi_slave_gen #(
      .DATA_W(16), .CPOL(g / 2), .CPHA(g % 2), .MSB_FIRST(0),
      .SYNC_STAGES(2), .TX_DEFAULT(16'h5AA5)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus16.slave)
    );
    assign bus16.sck      = sck_t[g];
    assign bus16.ssel     = ssel_t[g];
    assign bus16.mosi     = mosi_t[g];
    assign bus16.tx_data  = txd_t[g];
    assign bus16.tx_valid = txv_t[g];
    assign miso_w[g]      = bus16.miso;
    assign rdy_w[g]       = bus16.tx_ready;
    assign rxv_w[g]       = bus16.rx_valid;
    assign unr_w[g]       = bus16.tx_underrun;
    assign abt_w[g]       = bus16.frame_abort;
    assign rxd_w[g]       = bus16.rx_data;
  end

  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (rxv_w[k]) begin
        rxv_cnt[k] <= rxv_cnt[k] + 1;
        rx_last[k] <= rxd_w[k];
      end
      if (unr_w[k]) unr_cnt[k] <= unr_cnt[k] + 1;
      if (abt_w[k]) abt_cnt[k] <= abt_cnt[k] + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not end, time %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int m, input logic [15:0] d);
    int n;
    n = 0;
    txd_t[m] = d;
    txv_t[m] = 1'b1;
    while (!rdy_w[m] && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("push_timeout", 32'(n >= 400), 32'd0);
    @(negedge clk);
    txv_t[m] = 1'b0;
  endtask

  task automatic sel(input int m);
    @(negedge clk);
    ssel_t[m] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic desel(input int m);
    ssel_t[m] = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic xfer(input int m, input int nbits,
                      input logic [15:0] mo, output logic [15:0] mi);
    bit cpol, cpha, msb;
    int w, b;
    cpol = (m >= 2);
    cpha = (m % 2 == 1);
    msb  = (m == 0);
    w    = (m == 0) ? 8 : 16;
    mi   = '0;
    for (int i = 0; i < nbits; i++) begin
      b = msb ? (w - 1 - i) : i;
      if (!cpha) begin
        mosi_t[m] = mo[b];
        repeat (HALF) @(negedge clk);
        mi[b] = miso_w[m];
        sck_t[m] = ~cpol;
        repeat (HALF) @(negedge clk);
        sck_t[m] = cpol;
      end else begin
        sck_t[m] = ~cpol;
        mosi_t[m] = mo[b];
        repeat (HALF) @(negedge clk);
        mi[b] = miso_w[m];
        sck_t[m] = cpol;
        repeat (HALF) @(negedge clk);
      end
    end
    if (!cpha) repeat (HALF) @(negedge clk);
  endtask

  initial begin
    logic [15:0] mi;
    int r0, u0, a0;
    for (int k = 0; k < 4; k++) begin
      sck_t[k]  = (k >= 2);
      ssel_t[k] = 1'b1;
      mosi_t[k] = 1'b0;
      txd_t[k]  = '0;
      txv_t[k]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_tx_ready", 32'(if0.tx_ready), 32'd1);
    chk("rst_rx_valid", 32'(if0.rx_valid), 32'd0);
    chk("rst_rx_data", 32'(if0.rx_data), 32'd0);
    chk("rst_miso_oe", 32'(if0.miso_oe), 32'd0);
    chk("rst_frame_act", 32'(if0.frame_active), 32'd0);
    chk("rst_miso", 32'(if0.miso), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // mode 0, 8-bit MSB first
    push(0, 16'h00A5);
    chk("m0_hold_full", 32'(rdy_w[0]), 32'd0);
    u0 = unr_cnt[0];
    r0 = rxv_cnt[0];
    sel(0);
    chk("m0_frame_act", 32'(if0.frame_active), 32'd1);
    chk("m0_miso_oe", 32'(if0.miso_oe), 32'd1);
    chk("m0_ready_after_load", 32'(rdy_w[0]), 32'd1);
    push(0, 16'h0011);
    xfer(0, 8, 16'h003C, mi);
    chk("m0_miso_word", 32'(mi), 32'h00A5);
    chk("m0_rx_data", 32'(if0.rx_data), 32'h003C);
    chk("m0_rx_pulses", 32'(rxv_cnt[0] - r0), 32'd1);
    chk("m0_underruns", 32'(unr_cnt[0] - u0), 32'd0);
    desel(0);

    // modes 1..3, 16-bit LSB first
    for (int m = 1; m < 4; m++) begin
      push(m, 16'hBEEF);
      r0 = rxv_cnt[m];
      sel(m);
      xfer(m, 16, 16'h1234, mi);
      desel(m);
      chk($sformatf("mode%0d_miso", m), 32'(mi), 32'hBEEF);
      chk($sformatf("mode%0d_rx", m), 32'(rx_last[m]), 32'h1234);
      chk($sformatf("mode%0d_rxv", m), 32'(rxv_cnt[m] - r0), 32'd1);
    end

    // three words in one frame, one queued
    push(1, 16'h0F0F);
    r0 = rxv_cnt[1];
    u0 = unr_cnt[1];
    sel(1);
    xfer(1, 16, 16'h1111, mi);
    chk("mw_word1", 32'(mi), 32'h0F0F);
    xfer(1, 16, 16'h2222, mi);
    chk("mw_word2", 32'(mi), 32'h5AA5);
    xfer(1, 16, 16'h3333, mi);
    chk("mw_word3", 32'(mi), 32'h5AA5);
    desel(1);
    chk("mw_underruns", 32'(unr_cnt[1] - u0), 32'd2);
    chk("mw_rx_pulses", 32'(rxv_cnt[1] - r0), 32'd3);
    chk("mw_rx_last", 32'(rx_last[1]), 32'h3333);

    // abort after 5 of 8 bits, then a clean frame
    r0 = rxv_cnt[0];
    a0 = abt_cnt[0];
    sel(0);
    xfer(0, 5, 16'h00FF, mi);
    desel(0);
    chk("ab_abort", 32'(abt_cnt[0] - a0), 32'd1);
    chk("ab_no_rx", 32'(rxv_cnt[0] - r0), 32'd0);
    push(0, 16'h0096);
    sel(0);
    xfer(0, 8, 16'h00C3, mi);
    desel(0);
    chk("ab_next_miso", 32'(mi), 32'h0096);
    chk("ab_next_rx", 32'(if0.rx_data), 32'h00C3);
    chk("ab_next_rxv", 32'(rxv_cnt[0] - r0), 32'd1);
    chk("ab_no_extra", 32'(abt_cnt[0] - a0), 32'd1);

    // tx_valid held while the holding register is full
    push(1, 16'h1111);
    txd_t[1] = 16'h2222;
    txv_t[1] = 1'b1;
    repeat (4) @(negedge clk);
    chk("hv_not_ready", 32'(rdy_w[1]), 32'd0);
    u0 = unr_cnt[1];
    sel(1);
    xfer(1, 16, 16'hAAAA, mi);
    chk("hv_word1", 32'(mi), 32'h1111);
    chk("hv_captured", 32'(rdy_w[1]), 32'd0);
    txv_t[1] = 1'b0;
    xfer(1, 16, 16'h5555, mi);
    chk("hv_word2", 32'(mi), 32'h2222);
    desel(1);
    chk("hv_underruns", 32'(unr_cnt[1] - u0), 32'd0);

    // reset in the middle of a word
    push(0, 16'h0033);
    sel(0);
    xfer(0, 3, 16'h00F0, mi);
    rst_n = 1'b0;
    #1;
    chk("mr_frame_act", 32'(if0.frame_active), 32'd0);
    chk("mr_miso_oe", 32'(if0.miso_oe), 32'd0);
    chk("mr_tx_ready", 32'(if0.tx_ready), 32'd1);
    chk("mr_rx_data", 32'(if0.rx_data), 32'd0);
    chk("mr_miso", 32'(if0.miso), 32'd0);
    ssel_t[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    r0 = rxv_cnt[0];
    push(0, 16'h00E7);
    sel(0);
    xfer(0, 8, 16'h005A, mi);
    desel(0);
    chk("mr_next_rx", 32'(if0.rx_data), 32'h005A);
    chk("mr_next_miso", 32'(mi), 32'h00E7);
    chk("mr_next_rxv", 32'(rxv_cnt[0] - r0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/spi_slave_gen.md
Name: spi_slave_gen

Overview:
Parametrised SPI slave that supersedes the fixed 8-bit, mode-0 slave. It supports any word width, all four CPOL/CPHA modes, and MSB- or LSB-first ordering. Transmit data comes from a one-deep buffered valid/ready interface; received words go out as single-cycle strobes. It sits between the external SPI pins (after the IO ring) and the on-chip register or command logic. Everything runs in the system clock domain: the SPI pins are oversampled and never used as clocks.

Parameters:
DATA_W, 8, word width in bits (min 2).
CPOL, 0, idle level of sck.
CPHA, 0, 0 = sample on leading edge; 1 = sample on trailing edge.
MSB_FIRST, 1, 1 = MSB shifted first on both lines; 0 = LSB first.
SYNC_STAGES, 2, synchroniser depth for sck/mosi/ssel (min 2).
TX_DEFAULT, 0, word sent when no tx word is buffered.

Ports:
clk  in  1  system clock; sole clock of the block.
rst_n  in  1  asynchronous active-low reset.
sck  in  1  SPI clock from master (asynchronous).
mosi  in  1  master-out data (asynchronous).
ssel  in  1  active-low chip select (asynchronous).
miso  out  1  slave-out data.
miso_oe  out  1  tri-state enable for miso; high while selected.
tx_data  in  DATA_W  next word to transmit.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  holding register empty.
tx_underrun  out  1  1-cycle pulse: TX_DEFAULT was loaded.
rx_data  out  DATA_W  last completed received word.
rx_valid  out  1  1-cycle pulse: rx_data updated.
frame_active  out  1  synchronised ssel active.
frame_abort  out  1  1-cycle pulse: ssel rose with a partial word.

Behaviour:
- Clocking and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset values: all outputs 0, except tx_ready = 1. Synchroniser flops reset to the idle levels: sck = CPOL, ssel = 1, mosi = 0.
- Edge detection:
  - sck and ssel pass through SYNC_STAGES flops plus one history flop.
  - Leading edge = transition away from CPOL; trailing edge = transition back to CPOL.
  - Sample edge = leading if CPHA = 0, trailing if CPHA = 1. Shift edge = the other edge.
  - mosi uses the same depth, so it stays aligned with sck.
- Master constraint: sck high and low times must each be at least SYNC_STAGES + 2 clk cycles.
- Bit counter bitcnt:
  - Width $clog2(DATA_W).
  - Held at 0 while not frame_active.
  - Increments on each sample edge and wraps from DATA_W-1 to 0.
- Receive path:
  - On a sample edge, mosi is shifted in: into the LSB if MSB_FIRST, else into the MSB.
  - On the sample edge with bitcnt == DATA_W-1, the completed word is copied to rx_data and rx_valid pulses on the next clk.
  - No back-pressure: the consumer must take rx_data before the next word completes.
- Transmit path:
  - miso always drives the tx shift register's outgoing bit (MSB if MSB_FIRST, else LSB).
  - Load points, CPHA = 0: ssel start (falling edge), and the shift edge immediately after the last sample edge of a word.
  - Load points, CPHA = 1: the first leading edge of each word (bitcnt == 0).
  - At every other shift edge inside a frame, the register shifts by one.
  - At a load point, if the holding register is full: load it into the shift register, clear it, and raise tx_ready.
  - At a load point, if the holding register is empty: load TX_DEFAULT and pulse tx_underrun.
  - tx_valid && tx_ready captures tx_data into the holding register; tx_ready drops the next cycle.
  - tx_valid while tx_ready is low is ignored; the source must hold the word until accepted.
  - A capture and a load in the same cycle while the holding register is empty: the new word loads directly and tx_ready stays 1.
- miso_oe equals frame_active. miso is a don't-care when miso_oe = 0.
- Frame end (ssel rises):
  - If bitcnt != 0: pulse frame_abort and discard the partial word (no rx_valid).
  - bitcnt clears.
  - The holding register is kept for the next frame.
- ssel falls and an sck edge in the same cycle: the frame start takes priority and that sck edge is ignored.
- Reset mid-frame: everything returns to reset values immediately. The next ssel falling edge starts a clean frame.

Decomposition:
- Package spi_pkg: mode constants SPI_MODE0..3 as {CPOL, CPHA} pairs, and a function to compute the bit-counter width.
- Sub-module spi_edge_sync (rst_n, clk, async input, parameters SYNC_STAGES and IDLE):
  - Outputs the synchronised level plus rise and fall pulses.
  - Instantiated three times (sck, ssel, mosi).

Test Plan:
- Mode 0, DATA_W = 8, MSB first: tx word 0xA5 preloaded; master sends 0x3C -> miso bits 1,0,1,0,0,1,0,1; rx_data = 0x3C with one rx_valid pulse; no underrun.
- Sweep modes 1-3, DATA_W = 16, LSB first: master sends 0x1234, slave sends 0xBEEF -> both sides receive exact words in every mode.
- Multi-word frame of 3 words with only 1 tx word queued -> word 1 = queued value; words 2 and 3 = TX_DEFAULT with 2 tx_underrun pulses; 3 rx_valid pulses.
- ssel deasserted after 5 of 8 bits -> frame_abort pulses, no rx_valid; the next full frame receives correctly with bitcnt restarted.
- tx_valid held while tx_ready = 0 -> no overwrite; capture happens in the cycle after the load frees the register.
- rst_n asserted mid-word -> outputs return to reset values asynchronously; a subsequent frame transfers 0x5A cleanly.
